slow_intr_pending_ctrl: RTL
===========================

# slow_intr_pending_ctrl

Rising-edge interrupt pending controller in the slow clock domain, directly downstream of the fast-to-slow interrupt synchronizer. Takes the already-synchronized interrupt levels, detects rising edges, latches them into per-source pending bits, applies an enable mask, and drives one combined level interrupt to the CPU/PLIC. Software services the pending bits through a small single-cycle register port with write-1-to-clear semantics.

## Interface
- INTR_WIDTH, default 1: number of interrupt sources, 1..32.
- slow_clk  in  1  sole clock; all state updates on its rising edge.
- slow_resetn  in  1  asynchronous, active-low reset; deassertion synchronous to slow_clk upstream.
- slow_intr  in  INTR_WIDTH  synchronized interrupt levels from the synchronizer.
- reg_en  in  1  register access strobe, one cycle per access.
- reg_wr  in  1  1 = write, 0 = read; valid with reg_en.
- reg_addr  in  2  register select: 0 PENDING, 1 ENABLE, 2 RAW, 3 OVERFLOW.
- reg_wdata  in  32  write data; bits above INTR_WIDTH ignored.
- reg_rdata  out  32  read data, registered; bits above INTR_WIDTH read 0.
- reg_rvalid  out  1  one-cycle pulse, one cycle after a read strobe.
- irq_out  out  1  registered OR of (pending & enable).

## Operation
- Edge detect: per source, prev_q <= slow_intr; rise = slow_intr & ~prev_q. prev_q resets to 0, so a source high at reset release produces one edge.
- PENDING (addr 0): set by rise; write-1-to-clear via reg_wdata. Same-cycle rise and W1C on one bit: set wins (bit stays 1). Writes of 0 bits have no effect.
- ENABLE (addr 1): read/write, plain overwrite. Masking never blocks pending capture; a masked pending bit asserts irq_out as soon as enabled.
- RAW (addr 2): read-only, returns prev_q (current synchronized level). Writes ignored.
- OVERFLOW (addr 3, see Configuration): bit sets when rise occurs while the PENDING bit is already 1 and not being cleared that cycle; write-1-to-clear; set wins over clear.
- Reads: reg_rdata and reg_rvalid update the cycle after reg_en & ~reg_wr, sampling register state before that cycle's updates. reg_rdata holds its last value otherwise. Writes produce no reg_rvalid.
- Back-to-back accesses every cycle supported; no stall.

## Timing
- Reset values: prev_q, PENDING, ENABLE, OVERFLOW, reg_rdata, reg_rvalid, irq_out all 0.
- Edge-to-irq latency: slow_intr rises at cycle N -> PENDING set at edge N+1 -> irq_out high at edge N+2 (if enabled).
- W1C clear of last enabled pending bit at cycle M -> irq_out low at edge M+2.
- ENABLE write at M -> irq_out reflects new mask at edge M+2.
- Reset asserted mid-operation: all state clears immediately (asynchronously); edges in flight are lost; a level still high after release re-triggers one edge.
- A held-high level produces exactly one pending set; a new edge requires a low cycle.

## Configuration
- INTR_PEND_OVF_TRACK_EN defined: OVERFLOW register implemented as above.
- Not defined: no overflow flops; address 3 reads 0, writes ignored.

## Structure
- Package intr_pend_pkg: register address constants (ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_RAW=2, ADDR_OVERFLOW=3), register data width 32.
- One sub-module, intr_pend_bit: per-source edge detect, pending flop and overflow flop with set-wins-over-clear; instantiated INTR_WIDTH times via generate. Top holds ENABLE, read mux, irq_out.

## Test plan
- Reset check: INTR_WIDTH=4, all inputs 0 after reset -> all reads return 0, irq_out=0.
- Single edge: ENABLE=0x1, slow_intr[0] 0->1 at N -> PENDING=0x1 at N+1, irq_out=1 at N+2; W1C 0x1 -> irq_out=0 two cycles later; held high gives no re-trigger.
- Masking: ENABLE=0, edge on bit 2 -> PENDING=0x4, irq_out=0; write ENABLE=0x4 -> irq_out=1 two cycles later.
- Collision: edge on bit 1 in same cycle as W1C 0x2 -> PENDING bit 1 remains 1, irq_out stays/becomes 1.
- Overflow (macro defined): two separated edges on bit 3 without clear -> OVERFLOW=0x8; W1C 0x8 -> 0. Macro undefined -> address 3 reads 0.
- Reset mid-operation: PENDING=0xF, ENABLE=0xF, slow_intr=0x1 held; pulse slow_resetn low -> all registers 0, irq_out 0; after release PENDING=0x1 (re-detected edge).

Source files
------------

// File: rtl/intr_pend_pkg.sv
// Shared constants for the slow-domain interrupt pending controller:
// register map addresses and register data width.
package intr_pend_pkg;

    localparam int REG_DW = 32;

    localparam logic [1:0] ADDR_PENDING  = 2'd0;
    localparam logic [1:0] ADDR_ENABLE   = 2'd1;
    localparam logic [1:0] ADDR_RAW      = 2'd2;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd3;

endpackage

// File: rtl/intr_pend_bit.sv
// One interrupt source: rising-edge detect, pending flop and optional
// overflow flop (INTR_PEND_OVF_TRACK_EN); set always wins over clear.
module intr_pend_bit
    import intr_pend_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic intr_i,
    input  logic clr_pend_i,
    input  logic clr_ovf_i,
    output logic prev_o,
    output logic pend_o,
    output logic ovf_o
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise   = intr_i & ~prev_q;
    assign pend_d = rise | (pend_q & ~clr_pend_i);

    // Previous level and sticky pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= intr_i;
            pend_q <= pend_d;
        end
    end

    assign prev_o = prev_q;
    assign pend_o = pend_q;

`ifdef INTR_PEND_OVF_TRACK_EN
    logic ovf_q;
    logic ovf_d;

    // A new edge lands on a bit that is still pending and not being cleared.
    assign ovf_d = (rise & pend_q & ~clr_pend_i) | (ovf_q & ~clr_ovf_i);

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_clr_ovf;

    assign unused_clr_ovf = clr_ovf_i;
    assign ovf_o          = 1'b0;
`endif

endmodule

// File: rtl/slow_intr_pending_ctrl.sv
// Slow-domain rising-edge interrupt pending controller with W1C register
// port. Optional overflow tracking under INTR_PEND_OVF_TRACK_EN.
module slow_intr_pending_ctrl
    import intr_pend_pkg::*;
#(
    parameter int INTR_WIDTH = 1
) (
    input  logic                  slow_clk,
    input  logic                  slow_resetn,
    input  logic [INTR_WIDTH-1:0] slow_intr,
    input  logic                  reg_en,
    input  logic                  reg_wr,
    input  logic [1:0]            reg_addr,
    input  logic [REG_DW-1:0]     reg_wdata,
    output logic [REG_DW-1:0]     reg_rdata,
    output logic                  reg_rvalid,
    output logic                  irq_out
);

    localparam int W = INTR_WIDTH;

    logic          wr_s;
    logic          rd_s;
    logic [W-1:0]  clr_pend;
    logic [W-1:0]  clr_ovf;
    logic [W-1:0]  prev;
    logic [W-1:0]  pend;
    logic [W-1:0]  ovf;
    logic [W-1:0]  enable_q;
    logic [W-1:0]  enable_d;
    logic [REG_DW-1:0] rdata_q;
    logic [REG_DW-1:0] rdata_d;
    logic          rvalid_q;
    logic          irq_q;
    logic          irq_d;
    logic          unused_wdata;

    assign unused_wdata = ^reg_wdata;

    assign wr_s = reg_en & reg_wr;
    assign rd_s = reg_en & ~reg_wr;

    assign clr_pend = {W{wr_s && (reg_addr == ADDR_PENDING)}}
                    & reg_wdata[W-1:0];
    assign clr_ovf  = {W{wr_s && (reg_addr == ADDR_OVERFLOW)}}
                    & reg_wdata[W-1:0];

    for (genvar i = 0; i < W; i++) begin : g_bit
        intr_pend_bit u_bit (
            .clk        (slow_clk),
            .rst_n      (slow_resetn),
            .intr_i     (slow_intr[i]),
            .clr_pend_i (clr_pend[i]),
            .clr_ovf_i  (clr_ovf[i]),
            .prev_o     (prev[i]),
            .pend_o     (pend[i]),
            .ovf_o      (ovf[i])
        );
    end

    assign enable_d = (wr_s && (reg_addr == ADDR_ENABLE))
                    ? reg_wdata[W-1:0] : enable_q;

    assign irq_d = |(pend & enable_q);

    // Read mux sees state before this cycle's updates; unused bits read 0.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_s) begin
            rdata_d = '0;
            unique case (reg_addr)
                ADDR_PENDING:  rdata_d[W-1:0] = pend;
                ADDR_ENABLE:   rdata_d[W-1:0] = enable_q;
                ADDR_RAW:      rdata_d[W-1:0] = prev;
                ADDR_OVERFLOW: rdata_d[W-1:0] = ovf;
                default:       rdata_d = '0;
            endcase
        end
    end

    // Enable mask, registered read response and registered irq.
    always_ff @(posedge slow_clk or negedge slow_resetn) begin
        if (!slow_resetn) begin
            enable_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_s;
            irq_q    <= irq_d;
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
    assign irq_out    = irq_q;

endmodule
